aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_ctrl_pkg.sv | 13 +
 rtl/aes_round_cnt.sv | 31 +++
 rtl/aes_round_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round controller.
package aes_ctrl_pkg;
   localparam int AES128_ROUNDS = 10;
   localparam int RIDX_W        = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_e;
endpackage

// File: rtl/aes_round_cnt.sv
// Round index counter: synchronous clear, increment, saturates at NUM_ROUNDS.
module aes_round_cnt
   import aes_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [RIDX_W-1:0] cnt_o
);
   localparam logic [RIDX_W-1:0] CNT_MAX = RIDX_W'(NUM_ROUNDS);

   logic [RIDX_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: LOAD, NUM_ROUNDS-1 full rounds, one final round, then
// holds the result until taken. Define AES_ABORT_EN to add abort/zeroize.
module aes_round_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              start_valid,
   output logic              start_ready,
   output logic              ld_state,
   output logic              round_en,
   output logic              key_step,
   output logic [RIDX_W-1:0] round_idx,
   output logic              final_round,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
`ifdef AES_ABORT_EN
   ,
   input  logic              abort,
   output logic              zeroize
`endif
);
   localparam logic [RIDX_W-1:0] LAST_FULL = RIDX_W'(NUM_ROUNDS - 1);

   state_e state_q, state_d;
   logic   cnt_clr, cnt_inc;

   aes_round_cnt #(.NUM_ROUNDS(NUM_ROUNDS)) u_cnt (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .cnt_o  (round_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_inc = 1'b0;
      unique case (state_q)
         S_IDLE:  if (start_valid) state_d = S_LOAD;
         S_LOAD: begin
            cnt_inc = 1'b1;
            state_d = (NUM_ROUNDS > 1) ? S_ROUND : S_FINAL;
         end
         S_ROUND: begin
            cnt_inc = 1'b1;
            if (round_idx == LAST_FULL) state_d = S_FINAL;
         end
         S_FINAL: state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef AES_ABORT_EN
      // Abort wins over everything, including the DONE handshake.
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
`endif
      cnt_clr = (state_d == S_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

`ifdef AES_ABORT_EN
   logic zeroize_q;
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) zeroize_q <= 1'b0;
      else        zeroize_q <= abort && (state_q != S_IDLE);
   end
   assign zeroize = zeroize_q;
`endif

   // start_ready is gated by rst_n so every output reads 0 while in reset.
   assign start_ready = rst_n && (state_q == S_IDLE);
   assign ld_state    = (state_q == S_LOAD);
   assign round_en    = (state_q == S_ROUND) || (state_q == S_FINAL);
   assign key_step    = round_en;
   assign final_round = (state_q == S_FINAL);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
endmodule
